// File: rtl/rr3_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
// The pointer helpers encode the mod-3 phase sequence 0 -> 1 -> 2 -> 0.
package rr3_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 3;

    // Code 3 is illegal and always recovers to phase 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // First set request scanning ptr, ptr+1, ptr+2 (mod 3); an illegal ptr scans from 0.
    // Returns 0 when nothing is requesting.
    function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [NUM_REQ-1:0] req);
        logic [1:0] base;
        logic [1:0] idx;
        logic [1:0] win;
        int         s;
        base = (ptr == 2'd3) ? 2'd0 : ptr;
        win  = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(base) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = 2'(s);
            if (req[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/rr3_ptr.sv
// Mod-3 priority pointer register. On an advance strobe it loads the phase
// that follows 'from'; an illegal 'from' of 3 lands on phase 0.
module rr3_ptr
    import rr3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [1:0] from,
    output logic [1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (advance) begin
            ptr <= next_ptr(from);
        end
    end

endmodule

// File: rtl/rr3_arbiter.sv
// Three-requester round-robin arbiter with registered one-hot grant and a
// bounded hold time; every release is followed by at least one idle cycle.
module rr3_arbiter
    import rr3_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic [1:0]         ptr
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_GRANT = GRANT;

    // HOLD_MAX is legal in 1..2**CNT_W, so the last hold count always fits.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             start;
    logic             release_now;
    logic             owner_req;
    logic [1:0]       win;

    assign win       = pick(ptr, req);
    assign start     = (state == ST_IDLE) && en && (|req);
    // Only the owner's request matters while granted; masking avoids indexing with grant_id.
    assign owner_req = |(req & grant);
    assign release_now = (state == ST_GRANT) && (!owner_req || (hold_cnt == HOLD_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= 2'd0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_GRANT;
                        grant    <= NUM_REQ'(1) << win;
                        grant_id <= win;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        grant_id <= 2'd0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    grant    <= '0;
                    grant_id <= 2'd0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = |grant;

    // The pointer moves only on release, to the phase after the departing owner.
    rr3_ptr u_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (release_now),
        .from    (grant_id),
        .ptr     (ptr)
    );

endmodule

// File: tb/tb_rr3_arbiter.sv
// Randomised and directed bench for rr3_arbiter with a queue-based scoreboard
// fed by a cycle-level reference model of the round-robin rules.
module tb_rr3_arbiter;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic [1:0] ptr;

    always #5 clk = ~clk;

    rr3_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .ptr      (ptr)
    );

    int tests = 0;
    int fails = 0;

    // Expected word: {grant[2:0], grant_id[1:0], busy, ptr[1:0]}
    logic [7:0] exp_q[$];

    // Reference model: owner index (-1 when idle), cycles held so far, pointer.
    int m_owner;
    int m_hold;
    int m_ptr;

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic e, input logic [2:0] r);
        int i;
        if (m_owner < 0) begin
            if (e && r != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    i = (m_ptr + k) % 3;
                    if (r[i] && m_owner < 0) begin
                        m_owner = i;
                        m_hold  = 1;
                    end
                end
            end
        end else begin
            if (!r[m_owner] || m_hold == HOLD_MAX) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [7:0] model_word();
        logic [2:0] g;
        logic [1:0] id;
        g  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, id, (m_owner >= 0), 2'(m_ptr)};
    endfunction

    task automatic drive(input logic e, input logic [2:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        model_step(e, r);
        exp_q.push_back(model_word());
    endtask

    // Monitor: compares every registered output against the oldest expectation.
    initial begin : monitor
        logic [7:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("grant",    int'(grant),    int'(w[7:5]));
                check("grant_id", int'(grant_id), int'(w[4:3]));
                check("busy",     int'(busy),     int'(w[2]));
                check("ptr",      int'(ptr),      int'(w[1:0]));
            end
        end
    end

    initial begin : stimulus
        int len;
        logic [2:0] r;
        logic e;

        reset = 1'b1;
        en    = 1'b0;
        req   = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant",    int'(grant),    0);
        check("reset_grant_id", int'(grant_id), 0);
        check("reset_busy",     int'(busy),     0);
        check("reset_ptr",      int'(ptr),      0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-grant drops the grant without a clock edge.
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b001);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", int'(grant), 0);
        check("async_busy",  int'(busy),  0);
        check("async_ptr",   int'(ptr),   0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b000);
        drive(1'b1, 3'b000);

        // Rotation under constant full request.
        repeat (30) drive(1'b1, 3'b111);
        repeat (3) drive(1'b1, 3'b000);

        // Early release after three cycles.
        repeat (3) drive(1'b1, 3'b010);
        repeat (3) drive(1'b1, 3'b000);

        // Lone requester is forced off and re-wins.
        repeat (20) drive(1'b1, 3'b100);
        repeat (3) drive(1'b1, 3'b000);

        // en gating: blocks new grants, ignored while granted.
        repeat (3) drive(1'b0, 3'b011);
        drive(1'b1, 3'b011);
        repeat (4) drive(1'b0, 3'b011);
        repeat (2) drive(1'b0, 3'b000);

        // HOLD_MAX boundary with one requester dropping exactly at the limit.
        repeat (HOLD_MAX) drive(1'b1, 3'b010);
        repeat (2) drive(1'b1, 3'b000);

        // Randomised bursts of held request patterns.
        for (int n = 0; n < 80; n++) begin
            r   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                e = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 5) == 0) r = 3'($urandom_range(0, 7));
                drive(e, r);
            end
        end
        repeat (2) drive(1'b1, 3'b000);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
